// File: rtl/fact_host_ctrl.sv
// Bus master that runs one job on the factorial register block: write the operand, enable the interrupt and start, then wait for the interrupt, read the 64-bit result and clear the interrupt.
// Outputs decode from the state register, so M_* and done follow the state with no added latency. A low M_grant stalls REQ and bus states, and their outputs are held.
module fact_host_ctrl #(
  parameter logic [7:0]  BASE_ADDR = 8'h20,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] n_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] result,
  output logic        M_req,
  input  logic        M_grant,
  output logic        M_wr,
  output logic [7:0]  M_address,
  output logic [31:0] M_dout,
  input  logic [31:0] M_din,
  input  logic        f_interrupt
);

  typedef enum logic [3:0] {
    IDLE, REQ1, WR_OP, WR_IE, WR_GO, WAIT_IRQ, REQ2, RD_H, RD_L, WR_CLR, DONE
  } state_t;

  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [31:0] n_reg;
  logic [31:0] wait_cnt;
  logic        err_q;
  logic [63:0] result_q;
  logic        wait_hit;

  assign wait_hit = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      n_reg    <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        n_reg <= n_in;
        err_q <= 1'b0;
      end
      if (state == WR_GO && M_grant) begin
        wait_cnt <= '0;
      end else if (state == WAIT_IRQ && !f_interrupt) begin
        if (wait_hit) begin
          err_q <= 1'b1;
        end else if (wait_cnt != '1) begin
          wait_cnt <= wait_cnt + 32'd1;
        end
      end
      if (state == RD_H && M_grant) result_q[63:32] <= M_din;
      if (state == RD_L && M_grant) result_q[31:0]  <= M_din;
    end
  end

  always_comb begin
    next_state = state;
    M_req      = 1'b0;
    M_wr       = 1'b0;
    M_address  = 8'h00;
    M_dout     = 32'h0;
    case (state)
      IDLE: begin
        if (start) next_state = REQ1;
      end
      REQ1: begin
        M_req = 1'b1;
        if (M_grant) next_state = WR_OP;
      end
      WR_OP: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = BASE_ADDR;
        M_dout    = n_reg;
        if (M_grant) next_state = WR_IE;
      end
      WR_IE: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = BASE_ADDR + 8'd1;
        M_dout    = 32'd1;
        if (M_grant) next_state = WR_GO;
      end
      WR_GO: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = BASE_ADDR + 8'd3;
        M_dout    = 32'd1;
        if (M_grant) next_state = WAIT_IRQ;
      end
      WAIT_IRQ: begin
        if (f_interrupt || wait_hit) next_state = REQ2;
      end
      REQ2: begin
        M_req = 1'b1;
        // A timed-out job has nothing valid to read; go straight to the clear.
        if (M_grant) next_state = err_q ? WR_CLR : RD_H;
      end
      RD_H: begin
        M_req     = 1'b1;
        M_address = BASE_ADDR + 8'd5;
        if (M_grant) next_state = RD_L;
      end
      RD_L: begin
        M_req     = 1'b1;
        M_address = BASE_ADDR + 8'd6;
        if (M_grant) next_state = WR_CLR;
      end
      WR_CLR: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = BASE_ADDR + 8'd4;
        M_dout    = 32'd1;
        if (M_grant) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_fact_host_ctrl.sv
// Directed bench: main instance with default timeout plus a short-timeout instance for the abort path.
module tb_fact_host_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, start_to;
  logic [31:0] n_in, n_in_to;
  logic        grant, grant_to;
  logic        irq, irq_to;
  logic [31:0] h_val, l_val;

  logic        busy, done, err, M_req, M_wr;
  logic [63:0] result;
  logic [7:0]  M_address;
  logic [31:0] M_dout, M_din;

  logic        busy_to, done_to, err_to, req_to, wr_to;
  logic [63:0] result_to;
  logic [7:0]  addr_to;
  logic [31:0] dout_to, din_to;

  int checks = 0;
  int errors = 0;

  logic [63:0] log_q[$];
  int          done_cnt = 0;
  logic        err_at_done = 1'b0;
  int          done_cnt_to = 0;
  int          wait_cyc_to = 0;
  int          rd_cnt_to = 0;
  logic        err_at_done_to = 1'b0;
  logic [63:0] last_wr_to = '0;

  always #5 clk = ~clk;

  assign M_din  = (M_address == 8'h25) ? h_val : (M_address == 8'h26) ? l_val : 32'h0;
  assign din_to = (addr_to == 8'h26) ? 32'd6 : 32'h0;

  fact_host_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .n_in(n_in),
    .busy(busy), .done(done), .err(err), .result(result),
    .M_req(M_req), .M_grant(grant), .M_wr(M_wr), .M_address(M_address),
    .M_dout(M_dout), .M_din(M_din), .f_interrupt(irq)
  );

  fact_host_ctrl #(.BASE_ADDR(8'h20), .TIMEOUT(16)) dut_to (
    .clk(clk), .reset_n(reset_n), .start(start_to), .n_in(n_in_to),
    .busy(busy_to), .done(done_to), .err(err_to), .result(result_to),
    .M_req(req_to), .M_grant(grant_to), .M_wr(wr_to), .M_address(addr_to),
    .M_dout(dout_to), .M_din(din_to), .f_interrupt(irq_to)
  );

  function automatic logic [63:0] ent(input logic wr, input logic [7:0] a, input logic [31:0] d);
    return {23'd0, wr, a, d};
  endfunction

  always @(negedge clk) begin
    if (grant && M_wr) log_q.push_back(ent(1'b1, M_address, M_dout));
    else if (grant && M_address != 8'h00) log_q.push_back(ent(1'b0, M_address, M_din));
    if (done) begin
      done_cnt    <= done_cnt + 1;
      err_at_done <= err;
    end
    if (busy_to && !req_to && !done_to) wait_cyc_to <= wait_cyc_to + 1;
    if (grant_to && wr_to) last_wr_to <= {32'd0, addr_to, dout_to[23:0]};
    if (grant_to && !wr_to && addr_to != 8'h00) rd_cnt_to <= rd_cnt_to + 1;
    if (done_to) begin
      done_cnt_to    <= done_cnt_to + 1;
      err_at_done_to <= err_to;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] n);
    @(negedge clk);
    n_in  = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start_to(input logic [31:0] n);
    @(negedge clk);
    n_in_to  = n;
    start_to = 1'b1;
    @(negedge clk);
    start_to = 1'b0;
  endtask

  task automatic wait_wr_go();
    int t = 0;
    while (!(M_wr && grant && M_address == 8'h23) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("wr_go_seen", 64'(t < 200), 64'd1);
  endtask

  task automatic wait_done(input int base);
    int t = 0;
    while (done_cnt == base && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 64'(done_cnt > base), 64'd1);
  endtask

  task automatic wait_done_to(input int base);
    int t = 0;
    while (done_cnt_to == base && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("done_to_seen", 64'(done_cnt_to > base), 64'd1);
  endtask

  task automatic check_seq(input int base, input logic [31:0] n, input logic [31:0] h, input logic [31:0] l);
    chk("seq_len", 64'(log_q.size()), 64'(base + 6));
    if (log_q.size() >= base + 6) begin
      chk("seq_wr_op", log_q[base],     ent(1'b1, 8'h20, n));
      chk("seq_wr_ie", log_q[base + 1], ent(1'b1, 8'h21, 32'd1));
      chk("seq_wr_go", log_q[base + 2], ent(1'b1, 8'h23, 32'd1));
      chk("seq_rd_h",  log_q[base + 3], ent(1'b0, 8'h25, h));
      chk("seq_rd_l",  log_q[base + 4], ent(1'b0, 8'h26, l));
      chk("seq_clr",   log_q[base + 5], ent(1'b1, 8'h24, 32'd1));
    end
  endtask

  initial begin
    int base;
    int d0;
    int w0;
    int r0;
    logic hold_ok;
    reset_n = 1'b0; start = 1'b0; start_to = 1'b0; n_in = '0; n_in_to = '0;
    grant = 1'b1; grant_to = 1'b1; irq = 1'b0; irq_to = 1'b0;
    h_val = '0; l_val = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_req", 64'(M_req), 64'd0);
    chk("rst_wr", 64'(M_wr), 64'd0);
    chk("rst_addr", 64'(M_address), 64'd0);
    chk("rst_dout", 64'(M_dout), 64'd0);
    chk("rst_result", result, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Basic job: 4! with the interrupt 100 cycles after WR_GO.
    base = log_q.size(); d0 = done_cnt; h_val = 32'd0; l_val = 32'd24;
    pulse_start(32'd4);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_wr_go();
    @(negedge clk);
    chk("wait_req_low", 64'(M_req), 64'd0);
    chk("wait_addr_idle", {55'd0, M_wr, M_address}, 64'd0);
    repeat (99) @(negedge clk);
    irq = 1'b1;
    wait_done(d0);
    irq = 1'b0;
    @(negedge clk);
    check_seq(base, 32'd4, 32'd0, 32'd24);
    chk("res_4", result, 64'd24);
    chk("done_once_4", 64'(done_cnt - d0), 64'd1);
    chk("err_4", 64'(err_at_done), 64'd0);
    chk("busy_end_4", 64'(busy), 64'd0);

    // Grant withheld for 5 cycles after start.
    base = log_q.size(); d0 = done_cnt; l_val = 32'd6; grant = 1'b0;
    pulse_start(32'd3);
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(M_req && !M_wr && M_address == 8'h00 && M_dout == 32'h0)) hold_ok = 1'b0;
      @(negedge clk);
    end
    chk("grant_hold", 64'(hold_ok), 64'd1);
    chk("grant_no_log", 64'(log_q.size()), 64'(base));
    grant = 1'b1;
    wait_wr_go();
    repeat (10) @(negedge clk);
    irq = 1'b1;
    wait_done(d0);
    irq = 1'b0;
    @(negedge clk);
    check_seq(base, 32'd3, 32'd0, 32'd6);
    chk("res_3", result, 64'd6);

    // Second start while busy is ignored.
    base = log_q.size(); d0 = done_cnt; l_val = 32'd720;
    pulse_start(32'd6);
    wait_wr_go();
    repeat (3) @(negedge clk);
    pulse_start(32'd9);
    repeat (3) @(negedge clk);
    irq = 1'b1;
    wait_done(d0);
    irq = 1'b0;
    repeat (12) @(negedge clk);
    check_seq(base, 32'd6, 32'd0, 32'd720);
    chk("ignored_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("ignored_idle", 64'(busy), 64'd0);

    // 20! spans both result words.
    base = log_q.size(); d0 = done_cnt; h_val = 32'h21C3677C; l_val = 32'h82B40000;
    pulse_start(32'd20);
    wait_wr_go();
    repeat (5) @(negedge clk);
    irq = 1'b1;
    wait_done(d0);
    irq = 1'b0;
    @(negedge clk);
    check_seq(base, 32'd20, 32'h21C3677C, 32'h82B40000);
    chk("res_20", result, 64'h21C3677C82B40000);

    // Short-timeout instance: a good job, then one whose interrupt never comes.
    d0 = done_cnt_to; irq_to = 1'b1;
    pulse_start_to(32'd3);
    wait_done_to(d0);
    irq_to = 1'b0;
    @(negedge clk);
    chk("to_first_res", result_to, 64'd6);
    chk("to_first_err", 64'(err_at_done_to), 64'd0);
    d0 = done_cnt_to; w0 = wait_cyc_to; r0 = rd_cnt_to;
    pulse_start_to(32'd5);
    wait_done_to(d0);
    @(negedge clk);
    chk("to_wait_cycles", 64'(wait_cyc_to - w0), 64'd16);
    chk("to_err_at_done", 64'(err_at_done_to), 64'd1);
    chk("to_no_reads", 64'(rd_cnt_to - r0), 64'd0);
    chk("to_clr_write", last_wr_to, {32'd0, 8'h24, 24'd1});
    chk("to_res_kept", result_to, 64'd6);
    chk("to_err_sticky", 64'(err_to), 64'd1);
    d0 = done_cnt_to; irq_to = 1'b1;
    pulse_start_to(32'd2);
    chk("to_err_cleared", 64'(err_to), 64'd0);
    wait_done_to(d0);
    irq_to = 1'b0;

    // Asynchronous reset in WAIT_IRQ, then a fresh job.
    pulse_start(32'd7);
    wait_wr_go();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done_err", {62'd0, done, err}, 64'd0);
    chk("arst_bus", {23'd0, M_req, M_wr, M_address, M_dout[29:0]}, 64'd0);
    chk("arst_dout", 64'(M_dout), 64'd0);
    chk("arst_result", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    base = log_q.size(); d0 = done_cnt; h_val = 32'd0; l_val = 32'd120;
    pulse_start(32'd5);
    wait_wr_go();
    repeat (4) @(negedge clk);
    irq = 1'b1;
    wait_done(d0);
    irq = 1'b0;
    @(negedge clk);
    check_seq(base, 32'd5, 32'd0, 32'd120);
    chk("res_5", result, 64'd120);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_host_ctrl.md
FACT_HOST_CTRL -- requirements
Module: fact_host_ctrl

Interface
REQ-001 Parameter: BASE_ADDR, default 8'h20, bus address of the factorial register block.
REQ-002 Parameter: TIMEOUT, default 4096, maximum cycles to wait for f_interrupt before the job is aborted.
REQ-003 Register map, as offsets from BASE_ADDR: +0 OPERAND, +1 INTR_EN, +2 STATUS, +3 OPSTART, +4 INTR_CLR, +5 RESULT_H, +6 RESULT_L.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse requesting a factorial job; honoured only in IDLE.
REQ-007 n_in  input  32  operand N, sampled on the accepted start.
REQ-008 busy  output  1  high from the accepted start until DONE is left.
REQ-009 done  output  1  one-cycle pulse at job completion.
REQ-010 err  output  1  high together with done when the job timed out.
REQ-011 result  output  64  {RESULT_H, RESULT_L}; held until the next accepted start.
REQ-012 M_req  output  1  bus request to the arbiter.
REQ-013 M_grant  input  1  bus grant.
REQ-014 M_wr  output  1  1 = write, 0 = read.
REQ-015 M_address  output  8  bus address.
REQ-016 M_dout  output  32  write data.
REQ-017 M_din  input  32  read data, combinational from the addressed slave in the same cycle.
REQ-018 f_interrupt  input  1  factorial-complete interrupt, level, cleared by a write to INTR_CLR.

Function
REQ-019 States SHALL be IDLE, REQ1, WR_OP, WR_IE, WR_GO, WAIT_IRQ, REQ2, RD_H, RD_L, WR_CLR, DONE; each bus state lasts exactly one cycle.
REQ-020 IDLE: on start=1, latch n_in and go to REQ1; start outside IDLE SHALL be ignored.
REQ-021 REQ1 and REQ2: hold M_req=1 and M_wr=0 until M_grant=1, then advance on the next edge.
REQ-022 M_req SHALL remain 1 from REQ1 through WR_GO and from REQ2 through WR_CLR; it SHALL be 0 in WAIT_IRQ.
REQ-023 Write cycles, each with M_wr=1:
  - WR_OP: M_address=BASE+0, M_dout=N.
  - WR_IE: M_address=BASE+1, M_dout=1.
  - WR_GO: M_address=BASE+3, M_dout=1.
REQ-024 WAIT_IRQ: on f_interrupt=1, go to REQ2; otherwise increment the wait counter.
REQ-025 When the wait counter reaches TIMEOUT-1, set the err flag and go to REQ2, skipping RD_H and RD_L.
REQ-026 RD_H: M_wr=0, M_address=BASE+5; M_din is captured into result[63:32] at the closing edge.
REQ-027 RD_L: M_wr=0, M_address=BASE+6; M_din is captured into result[31:0] at the closing edge.
REQ-028 WR_CLR: M_wr=1, M_address=BASE+4, M_dout=1; then go to DONE.
REQ-029 DONE: assert done=1 for one cycle (err=1 as well if the job timed out), then return to IDLE.
REQ-030 Outside bus states, M_wr=0, M_address=8'h00, M_dout=0.
REQ-031 If M_grant drops during a write or read state, the FSM SHALL stall in that state with its outputs held until M_grant returns.
REQ-032 A job with N=0 SHALL be issued normally; N SHALL NOT be range-checked.
REQ-033 The wait counter is 32 bits wide, clears on entry to WAIT_IRQ, and SHALL NOT wrap.
REQ-034 err SHALL be cleared by the next accepted start.

Reset
REQ-035 reset_n=0 SHALL immediately force:
  - state IDLE;
  - busy, done, err, M_req and M_wr = 0;
  - M_address = 8'h00, M_dout = 0;
  - result = 0 and the wait counter = 0.
REQ-036 Reset during any state SHALL abort the job with no further bus cycles; the first start after reset_n returns high SHALL be accepted.

Verification
REQ-037 start with n_in=4, grant tied 1, f_interrupt raised 100 cycles after WR_GO, slave returns H=0 and L=24 -> bus writes in order 0x20=4, 0x21=1, 0x23=1; reads 0x25 then 0x26; write 0x24=1; result=64'd24; single done pulse; err=0.
REQ-038 M_grant held 0 for 5 cycles after start -> M_req=1 throughout, no M_wr/M_address activity until the grant; then the REQ-037 sequence follows.
REQ-039 f_interrupt never asserted, TIMEOUT=16 -> 16 cycles in WAIT_IRQ, then the 0x24=1 write; done=1 and err=1; result keeps its previous value.
REQ-040 reset_n pulsed low during WAIT_IRQ -> all outputs at reset values asynchronously, before the next clock edge; a new start with n_in=5 completes normally.
REQ-041 second start pulse while busy -> ignored; exactly one bus sequence and one done pulse.
REQ-042 n_in=20, slave returns H=32'h21C3677C and L=32'h82B40000 -> result=64'h21C3677C82B40000 (20!).
